// File: rtl/chan_readout_sequencer.sv
// Serial readout sequencer: walks enabled channels and their counter registers through the
// serial-out mux. Optional per-channel header frame enabled by READOUT_HEADER_EN.
module chan_readout_sequencer #(
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned NUM_REG       = 5,
    parameter int unsigned REG_BITS      = 10,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] channel_mask,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] mux_control_signal,
    output logic [2:0]        select_reg,
    output logic [NUM_CH-1:0] load_cnt_ser,
    output logic              frame_valid,
    output logic [3:0]        bit_index,
    output logic              header_valid,
    output logic              header_bit
);

    localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSeek,
        StLoad,
        StSettle,
        StShift,
`ifdef READOUT_HEADER_EN
        StHeader,
`endif
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] work_q, work_d;
    logic [ChW-1:0]    ch_q, ch_d, seek_ch;
    logic [2:0]        reg_q, reg_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] ch_onehot, seek_onehot, remain;
`ifdef READOUT_HEADER_EN
    logic [3:0]        hdr;
`endif

    // Lowest-indexed channel still pending in the working mask.
    always_comb begin
        seek_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (work_q[i]) seek_ch = ChW'(i);
        end
    end

    assign ch_onehot   = NUM_CH'(1) << ch_q;
    assign seek_onehot = NUM_CH'(1) << seek_ch;
    assign remain      = work_q & ~ch_onehot;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            work_q  <= '0;
            ch_q    <= '0;
            reg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            ch_q    <= ch_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        ch_d    = ch_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StIdle;
            work_d  = '0;
            ch_d    = '0;
            reg_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (|channel_mask) begin
                            work_d  = channel_mask;
                            state_d = StSeek;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StSeek: begin
                    ch_d  = seek_ch;
                    reg_d = '0;
                    cnt_d = '0;
`ifdef READOUT_HEADER_EN
                    state_d = StHeader;
`else
                    state_d = StLoad;
`endif
                end
`ifdef READOUT_HEADER_EN
                StHeader: begin
                    if (cnt_q == 4'd3) begin
                        cnt_d   = '0;
                        state_d = StLoad;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`endif
                StLoad: begin
                    cnt_d   = '0;
                    state_d = (SETTLE_CYCLES == 0) ? StShift : StSettle;
                end
                StSettle: begin
                    if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = StShift;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StShift: begin
                    // Last shift bit also performs the register/channel advance.
                    if (cnt_q == 4'(REG_BITS - 1)) begin
                        cnt_d = '0;
                        if (reg_q != 3'(NUM_REG - 1)) begin
                            reg_d   = reg_q + 3'd1;
                            state_d = StLoad;
                        end else begin
                            reg_d   = '0;
                            work_d  = remain;
                            state_d = (|remain) ? StSeek : StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    work_d  = '0;
                    ch_d    = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef READOUT_HEADER_EN
    assign hdr = {1'b1, 3'(ch_q)};
`endif

    always_comb begin
        busy               = 1'b0;
        done               = 1'b0;
        mux_control_signal = '0;
        select_reg         = '0;
        load_cnt_ser       = '0;
        frame_valid        = 1'b0;
        bit_index          = '0;
        header_valid       = 1'b0;
        header_bit         = 1'b0;
        case (state_q)
            StSeek: begin
                busy               = 1'b1;
                mux_control_signal = seek_onehot;
            end
`ifdef READOUT_HEADER_EN
            StHeader: begin
                busy               = 1'b1;
                mux_control_signal = ch_onehot;
                header_valid       = 1'b1;
                header_bit         = hdr[2'd3 - cnt_q[1:0]];
            end
`endif
            StLoad: begin
                busy               = 1'b1;
                mux_control_signal = ch_onehot;
                select_reg         = reg_q;
                load_cnt_ser       = ch_onehot;
            end
            StSettle: begin
                busy               = 1'b1;
                mux_control_signal = ch_onehot;
                select_reg         = reg_q;
            end
            StShift: begin
                busy               = 1'b1;
                mux_control_signal = ch_onehot;
                select_reg         = reg_q;
                frame_valid        = 1'b1;
                bit_index          = cnt_q;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule
